// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick front end for arcade cores: ps2_key events are decoded by scanning a
// run-time loadable keymap, merged with joystick inputs, optionally rotated and coin-stretched.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAP_DEPTH   = 32,
  parameter int COIN_MIN    = 1200000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]    joy_in,
  input  logic                         rotate,
  input  logic                         rotate_ccw,
  input  logic                         kbd_clear,
  input  logic                         map_we,
  input  logic [$clog2(MAP_DEPTH)-1:0] map_addr,
  input  logic [15:0]                  map_wdata,
  output logic [8*NUM_PLAYERS-1:0]     btn_out,
  output logic                         busy,
  output logic                         overflow
);

  localparam int AW = $clog2(MAP_DEPTH);
  localparam int CW = $clog2(COIN_MIN + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(MAP_DEPTH - 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_MIN - 1);

  typedef struct packed {
    logic       pressed;
    logic [8:0] code;
  } ev_t;

  typedef logic [NUM_PLAYERS-1:0][7:0] key_vec_t;

  logic [MAP_DEPTH-1:0] map_valid_q;
  logic [14:0]          map_data_q [MAP_DEPTH];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          toggle_q;
  ev_t           cur_q, cur_d;
  ev_t           pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          overflow_q, overflow_d;
  key_vec_t      work_q, work_d;
  key_vec_t      key_q, key_d;
  key_vec_t      work_upd;

  logic          ev_strobe;
  ev_t           new_ev;
  logic [14:0]   ent;
  logic          ent_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      map_valid_q <= '0;
    end else if (map_we) begin
      map_valid_q[map_addr] <= map_wdata[15];
    end
  end

  // NOTE: only the valid bits are reset; the payload array stays unreset so it maps to plain storage.
  always_ff @(posedge clk_sys) begin
    if (map_we) begin
      map_data_q[map_addr] <= map_wdata[14:0];
    end
  end

  assign ev_strobe = ps2_key[10] ^ toggle_q;
  assign new_ev    = ev_t'(ps2_key[9:0]);
  assign ent       = map_data_q[idx_q];
  assign ent_hit   = (state_q == ST_SCAN) && map_valid_q[idx_q] &&
                     (ent[14] ? (ent[7:0] == cur_q.code[7:0]) : (ent[8:0] == cur_q.code));

  // Matches accumulate in a working copy that is committed after the last entry.
  always_comb begin
    work_upd = work_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (ent_hit && (ent[13:12] == 2'(p))) begin
        work_upd[p][ent[11:9]] = cur_q.pressed;
      end
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overflow_d   = overflow_q;
    work_d       = work_q;
    key_d        = key_q;
    if (kbd_clear) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      pend_valid_d = 1'b0;
      overflow_d   = 1'b0;
      key_d        = '0;
    end else if (state_q == ST_IDLE) begin
      if (ev_strobe) begin
        state_d = ST_SCAN;
        idx_d   = '0;
        cur_d   = new_ev;
        work_d  = key_q;
      end
    end else if (idx_q != LAST_IDX) begin
      idx_d  = idx_q + AW'(1);
      work_d = work_upd;
      if (ev_strobe) begin
        if (pend_valid_q) begin
          overflow_d = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_d       = new_ev;
        end
      end
    end else begin
      key_d  = work_upd;
      work_d = work_upd;
      idx_d  = '0;
      if (pend_valid_q) begin
        cur_d        = pend_q;
        pend_valid_d = ev_strobe;
        if (ev_strobe) begin
          pend_d = new_ev;
        end
      end else if (ev_strobe) begin
        cur_d = new_ev;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      toggle_q     <= 1'b0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      work_q       <= '0;
      key_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      toggle_q     <= ps2_key[10];
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      work_q       <= work_d;
      key_q        <= key_d;
    end
  end

  assign busy     = (state_q == ST_SCAN);
  assign overflow = overflow_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic [15:0]   joy;
    logic [7:0]    unused_joy;
    logic [7:0]    joy_btn;
    logic [7:0]    raw;
    logic [3:0]    dirs;
    logic [CW-1:0] coin_cnt_q, coin_cnt_d;
    logic          coin_prev_q;
    logic [7:0]    btn_q, btn_d;

    assign joy        = joy_in[16*g +: 16];
    assign unused_joy = joy[15:8];
    // Joystick order R,L,D,U,fire1,start,coin,fire2 -> button order U,D,L,R,fire1,fire2,start,coin.
    assign joy_btn    = {joy[6], joy[5], joy[7], joy[4], joy[0], joy[1], joy[2], joy[3]};
    assign raw        = key_q[g] | joy_btn;

    assign dirs = !rotate   ? raw[3:0] :
                  rotate_ccw ? {raw[1], raw[0], raw[2], raw[3]} :
                               {raw[0], raw[1], raw[3], raw[2]};

    assign coin_cnt_d = (raw[7] && !coin_prev_q) ? COIN_LOAD :
                        (coin_cnt_q != '0)       ? coin_cnt_q - CW'(1) : coin_cnt_q;
    assign btn_d      = {raw[7] | (coin_cnt_q != '0), raw[6:4], dirs};

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        coin_cnt_q  <= '0;
        coin_prev_q <= 1'b0;
        btn_q       <= '0;
      end else begin
        coin_cnt_q  <= coin_cnt_d;
        coin_prev_q <= raw[7];
        btn_q       <= btn_d;
      end
    end

    assign btn_out[8*g +: 8] = btn_q;
  end

endmodule
